// File: rtl/memory_pkg.sv
// Shared types and constants for the memory (M) pipeline stage.
// The sub-word access path is only built when MEM_SUBWORD_EN is defined;
// the constants below are harmless in the word-only build.
package memory_pkg;

    // Access FSM: IDLE issues new requests, WAIT holds the pipeline until
    // the data memory answers or the wait budget runs out.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } memState_e;

    // RISC-V load funct3 encodings.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // RISC-V store funct3 encodings.
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Access sizes as carried in funct3[1:0].
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size field of funct3; the unused encoding 2'b11 is treated as a word.
    function automatic logic [1:0] accessSize(input logic [2:0] funct3);
        logic [1:0] size;
        size = funct3[1:0];
        if (size == 2'b11) begin
            size = SZ_WORD;
        end
        return size;
    endfunction

    // True when funct3 asks for a zero-extended load (LBU/LHU).
    function automatic logic isUnsignedLoad(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for data-memory accesses: byte enables, store data
// replication, load extraction and sign/zero extension.
// Sub-word support is compiled in only with MEM_SUBWORD_EN defined;
// otherwise every access is a full aligned word and funct3 is ignored.
module load_store_align
    import memory_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addrLow_i,
    input  logic [31:0] storeData_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] loadData_o,
    output logic        misaligned_o
);

`ifdef MEM_SUBWORD_EN

    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic        zeroExt;

    // Select the addressed byte and halfword out of the returned word.
    always_comb begin
        laneByte = rdata_i[7:0];
        case (addrLow_i)
            2'd0:    laneByte = rdata_i[7:0];
            2'd1:    laneByte = rdata_i[15:8];
            2'd2:    laneByte = rdata_i[23:16];
            default: laneByte = rdata_i[31:24];
        endcase
        laneHalf = addrLow_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    assign zeroExt = isUnsignedLoad(funct3_i);

    // Build enables, replicate store data and extend load data by size.
    always_comb begin
        be_o         = 4'hF;
        wdata_o      = storeData_i;
        loadData_o   = rdata_i;
        misaligned_o = 1'b0;
        case (accessSize(funct3_i))
            SZ_BYTE: begin
                be_o       = 4'b0001 << addrLow_i;
                wdata_o    = {4{storeData_i[7:0]}};
                loadData_o = zeroExt ? {24'd0, laneByte}
                                     : {{24{laneByte[7]}}, laneByte};
            end
            SZ_HALF: begin
                be_o         = addrLow_i[1] ? 4'b1100 : 4'b0011;
                wdata_o      = {2{storeData_i[15:0]}};
                loadData_o   = zeroExt ? {16'd0, laneHalf}
                                       : {{16{laneHalf[15]}}, laneHalf};
                misaligned_o = addrLow_i[0];
            end
            default: begin
                be_o         = 4'hF;
                wdata_o      = storeData_i;
                loadData_o   = rdata_i;
                misaligned_o = |addrLow_i;
            end
        endcase
    end

`else

    logic unusedInputs;

    assign be_o         = 4'hF;
    assign wdata_o      = storeData_i;
    assign loadData_o   = rdata_i;
    assign misaligned_o = 1'b0;
    assign unusedInputs = ^{funct3_i, addrLow_i};

`endif

endmodule

// File: rtl/memory_cycle.sv
// Memory (M) stage of the pipeline: branch resolution towards fetch, a
// two-state data-memory handshake FSM with a wait timeout, and the M-to-W
// pipeline register.  Define MEM_SUBWORD_EN to enable byte/halfword
// loads and stores; the default build is word-only.
module memory_cycle
    import memory_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        BranchM,
    input  logic        RegWriteM,
    input  logic        MemReadM,
    input  logic        memtoRegM,
    input  logic        MemWriteM,
    input  logic        ZeroM,
    input  logic [31:0] InstrM,
    input  logic [31:0] ReadData2M,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] PCTargetM,

    output logic        PCSrcM,
    output logic [31:0] PCTargetF,
    output logic        stallM,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,

    output logic        RegWriteW,
    output logic        memtoRegW,
    output logic        ValidW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  RdW,

    output logic        dmem_err
);

    // The counter only has to reach TIMEOUT-1: the WAIT cycle seen with
    // that count and no ready is the one that gives up.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    memState_e      state_q, state_d;
    logic [CW-1:0]  waitCnt_q, waitCnt_d;
    logic           dmemErr_q, dmemErr_d;

    logic           regWriteW_q;
    logic           memtoRegW_q;
    logic           validW_q;
    logic [31:0]    readDataW_q, readDataW_d;
    logic [31:0]    aluOutW_q;
    logic [4:0]     rdW_q;

    logic           memOp;
    logic           isLoad;
    logic           reqRaw;
    logic           stallRaw;
    logic           timeout;
    logic           misaligned;
    logic [31:0]    loadData;
    logic           unusedInstr;

    // A load+store combination is a store; only a pure read is a load.
    assign memOp       = MemReadM | MemWriteM;
    assign isLoad      = MemReadM & ~MemWriteM;
    assign unusedInstr = ^{InstrM[31:15], InstrM[6:0]};

    // Branch decision and target go straight back to fetch.
    assign PCSrcM    = BranchM & ZeroM;
    assign PCTargetF = PCTargetM;

    load_store_align u_align (
        .funct3_i     (InstrM[14:12]),
        .addrLow_i    (ALUOutM[1:0]),
        .storeData_i  (ReadData2M),
        .rdata_i      (dmem_rdata),
        .be_o         (dmem_be),
        .wdata_o      (dmem_wdata),
        .loadData_o   (loadData),
        .misaligned_o (misaligned)
    );

    assign dmem_addr = {ALUOutM[31:2], 2'b00};

    // Next-state and handshake decode; the last allowed WAIT cycle without
    // ready releases the stall so the instruction retires with zero data.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = '0;
        reqRaw    = 1'b0;
        stallRaw  = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            IDLE: begin
                reqRaw   = memOp & ~misaligned;
                stallRaw = reqRaw & ~dmem_ready;
                if (stallRaw) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                reqRaw   = 1'b1;
                timeout  = ~dmem_ready & (waitCnt_q == LAST_WAIT);
                stallRaw = ~dmem_ready & ~timeout;
                if (dmem_ready || timeout) begin
                    state_d = IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset must kill an outstanding request at once, not at the next edge,
    // so the raw decode is masked with rst.
    assign dmem_req = reqRaw & ~rst;
    assign dmem_we  = reqRaw & MemWriteM & ~rst;
    assign stallM   = stallRaw & ~rst;

    // Load data only counts when a load actually completed this cycle;
    // stores, non-memory ops, misaligned accesses and timeouts retire zero.
    always_comb begin
        readDataW_d = '0;
        if (isLoad && reqRaw && dmem_ready) begin
            readDataW_d = loadData;
        end
        dmemErr_d = dmemErr_q | timeout;
    end

    // FSM state, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            dmemErr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            dmemErr_q <= dmemErr_d;
        end
    end

    // M-to-W register: advance when not stalled, otherwise insert a bubble
    // while keeping the data fields of the last retired instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWriteW_q <= 1'b0;
            memtoRegW_q <= 1'b0;
            validW_q    <= 1'b0;
            readDataW_q <= '0;
            aluOutW_q   <= '0;
            rdW_q       <= '0;
        end else if (stallRaw) begin
            regWriteW_q <= 1'b0;
            validW_q    <= 1'b0;
        end else begin
            regWriteW_q <= RegWriteM;
            memtoRegW_q <= memtoRegM;
            validW_q    <= 1'b1;
            readDataW_q <= readDataW_d;
            aluOutW_q   <= ALUOutM;
            rdW_q       <= InstrM[11:7];
        end
    end

    assign RegWriteW = regWriteW_q;
    assign memtoRegW = memtoRegW_q;
    assign ValidW    = validW_q;
    assign ReadDataW = readDataW_q;
    assign ALUOutW   = aluOutW_q;
    assign RdW       = rdW_q;
    assign dmem_err  = dmemErr_q;

endmodule
